microwave_cook_ctrl: RTL
========================

MICROWAVE_COOK_CTRL -- requirements
Module: microwave_cook_ctrl

Interface
REQ-001 SHALL have parameter TICKS_PER_SEC, default 100, clk cycles per cook-time second (>=2).
REQ-002 SHALL have parameter TIME_W, default 12, width of the cook-time seconds counter.
REQ-003 SHALL have parameter BEEP_SEC, default 3, seconds the beep stays asserted after completion (>=1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst_n  input  1  reset is asynchronous and active-low.
REQ-006 start  input  1  start/resume button, synchronous level, active-high.
REQ-007 stop  input  1  stop/pause button, synchronous level, active-high.
REQ-008 clear  input  1  clear/cancel button, synchronous level, active-high.
REQ-009 door_closed  input  1  1 = door closed and latched.
REQ-010 load  input  1  one-cycle strobe; captures cook_time.
REQ-011 cook_time  input  TIME_W  requested seconds.
REQ-012 magnetron_on  output  1  heating enable.
REQ-013 lamp_on  output  1  cavity lamp.
REQ-014 remaining  output  TIME_W  seconds left.
REQ-015 done  output  1  one-cycle pulse at cook completion.
REQ-016 beep  output  1  completion buzzer.
REQ-017 state  output  2  current state encoding.

Function
REQ-018 start, stop and clear SHALL be rising-edge detected internally; a held button acts once.
REQ-019 States SHALL be IDLE=0, COOKING=1, PAUSED=2, DONE=3.
REQ-020 Per-cycle priority SHALL be: clear edge > door_closed=0 > stop edge > second tick > start edge.
REQ-021 IDLE: load SHALL set remaining=cook_time next cycle; load in any other state SHALL be ignored.
REQ-022 IDLE: start edge with door_closed=1 and remaining!=0 SHALL enter COOKING with prescaler cleared; otherwise SHALL stay IDLE.
REQ-023 IDLE: clear edge SHALL set remaining=0.
REQ-024 COOKING: prescaler SHALL count 0..TICKS_PER_SEC-1; at terminal count remaining SHALL decrement by 1 and prescaler wrap to 0.
REQ-025 COOKING: decrement from 1 to 0 SHALL enter DONE and pulse done for exactly that transition cycle+1 (one cycle, registered).
REQ-026 COOKING: door_closed=0 or stop edge SHALL enter PAUSED; prescaler SHALL hold its value.
REQ-027 COOKING or PAUSED: clear edge SHALL enter IDLE with remaining=0 and prescaler=0.
REQ-028 PAUSED: start edge with door_closed=1 SHALL resume COOKING from held prescaler and remaining; stop edge SHALL behave as clear.
REQ-029 DONE: beep=1 for BEEP_SEC seconds counted by the prescaler, then IDLE; any button edge or door opening SHALL end DONE immediately (IDLE, beep=0).
REQ-030 magnetron_on SHALL equal (state==COOKING) AND door_closed, combinationally, so door opening removes heating in the same cycle.
REQ-031 lamp_on SHALL equal (state==COOKING) OR NOT door_closed.
REQ-032 remaining SHALL never wrap below 0; no decrement occurs when remaining=0.

Reset
REQ-033 rst_n=0 SHALL asynchronously force state=IDLE, remaining=0, prescaler=0, beep counter=0, edge-detect history=0, done=0, beep=0.
REQ-034 magnetron_on SHALL be 0 throughout reset; reset mid-COOKING SHALL discard remaining time.
REQ-035 After rst_n deasserts, a button already held SHALL NOT count as an edge until released and re-pressed.

Structure
REQ-036 Package microwave_pkg SHALL hold the state enum and default parameter constants.
REQ-037 Prescaler SHALL be a sub-module mw_tick_gen (inputs enable, clr; output tick on terminal count).
REQ-038 Remaining-time counter, edge detectors and FSM SHALL reside in microwave_cook_ctrl.

Verification (TICKS_PER_SEC=4, TIME_W=8, BEEP_SEC=2)
REQ-039 load cook_time=3, door_closed=1, start pulse -> COOKING, magnetron_on=1, remaining 3->2->1->0 every 4 cycles, done single pulse, beep=1 for 8 cycles, then IDLE.
REQ-040 Cooking remaining=2, door_closed to 0 -> magnetron_on=0 same cycle, lamp_on=1, PAUSED, remaining holds 2; close door + start -> resumes, prescaler continues from held value.
REQ-041 start held high across full cook -> only one start action; no restart from DONE.
REQ-042 PAUSED with remaining=5, stop edge -> IDLE, remaining=0; start in IDLE with remaining=0 -> stays IDLE.
REQ-043 clear and start edges same cycle in IDLE after load 4 -> remaining=0, stays IDLE.
REQ-044 rst_n low mid-COOKING (remaining=6) -> immediately IDLE, remaining=0, magnetron_on=0, no done pulse.

Source files
------------

// File: rtl/microwave_pkg.sv
// Shared state encoding and default timing constants for the microwave cook controller.
package microwave_pkg;

    localparam int unsigned DEF_TICKS_PER_SEC = 100;
    localparam int unsigned DEF_TIME_W        = 12;
    localparam int unsigned DEF_BEEP_SEC      = 3;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COOKING = 2'd1,
        ST_PAUSED  = 2'd2,
        ST_DONE    = 2'd3
    } state_t;

endpackage

// File: rtl/mw_tick_gen.sv
// Seconds prescaler: counts 0..TICKS_PER_SEC-1 while enabled, flags the terminal count.
module mw_tick_gen
    import microwave_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC
) (
    input  logic clk,
    input  logic rst_n,
    input  logic enable,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = $clog2(TICKS_PER_SEC);
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICKS_PER_SEC - 1);

    logic [CNT_W-1:0] cnt;

    // Holds its value whenever enable is low so a pause resumes mid-second.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == TERM) ? '0 : cnt + CNT_W'(1);
        end
    end

    assign tick = enable && (cnt == TERM);

endmodule

// File: rtl/microwave_cook_ctrl.sv
// Microwave cook controller: button edge detection, remaining-time counter and
// the IDLE/COOKING/PAUSED/DONE sequencer with completion beep.
module microwave_cook_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned TICKS_PER_SEC = DEF_TICKS_PER_SEC,
    parameter int unsigned TIME_W        = DEF_TIME_W,
    parameter int unsigned BEEP_SEC      = DEF_BEEP_SEC
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              clear,
    input  logic              door_closed,
    input  logic              load,
    input  logic [TIME_W-1:0] cook_time,
    output logic              magnetron_on,
    output logic              lamp_on,
    output logic [TIME_W-1:0] remaining,
    output logic              done,
    output logic              beep,
    output logic [1:0]        state
);

    localparam int unsigned BEEP_W = (BEEP_SEC > 1) ? $clog2(BEEP_SEC) : 1;
    localparam logic [BEEP_W-1:0] BEEP_LAST = BEEP_W'(BEEP_SEC - 1);

    state_t            st;
    logic [BEEP_W-1:0] beep_cnt;
    logic              start_q, stop_q, clear_q;
    logic              hist_valid;
    logic              start_edge, stop_edge, clear_edge;
    logic              tick;
    logic              tick_en, tick_clr;

    // Edges are suppressed until history holds one real sample after reset,
    // so a button held through reset release does not act.
    assign start_edge = hist_valid && start && !start_q;
    assign stop_edge  = hist_valid && stop  && !stop_q;
    assign clear_edge = hist_valid && clear && !clear_q;

    // Prescaler runs only when no higher-priority event preempts the tick.
    assign tick_en  = ((st == ST_COOKING) || (st == ST_DONE))
                      && door_closed && !stop_edge && !clear_edge;
    assign tick_clr = clear_edge || (st == ST_IDLE)
                      || ((st == ST_PAUSED) && door_closed && stop_edge);

    mw_tick_gen #(
        .TICKS_PER_SEC(TICKS_PER_SEC)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .enable(tick_en),
        .clr   (tick_clr),
        .tick  (tick)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            clear_q    <= 1'b0;
            hist_valid <= 1'b0;
        end else begin
            start_q    <= start;
            stop_q     <= stop;
            clear_q    <= clear;
            hist_valid <= 1'b1;
        end
    end

    // Sequencer; priority: clear > door open > stop > second tick > start.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            remaining <= '0;
            beep_cnt  <= '0;
            done      <= 1'b0;
            beep      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (st)
                ST_IDLE: begin
                    if (clear_edge) begin
                        remaining <= '0;
                    end else begin
                        if (load) begin
                            remaining <= cook_time;
                        end
                        if (door_closed && !stop_edge && start_edge && (remaining != '0)) begin
                            st <= ST_COOKING;
                        end
                    end
                end
                ST_COOKING: begin
                    if (clear_edge) begin
                        st        <= ST_IDLE;
                        remaining <= '0;
                    end else if (!door_closed || stop_edge) begin
                        st <= ST_PAUSED;
                    end else if (tick && (remaining != '0)) begin
                        remaining <= remaining - TIME_W'(1);
                        if (remaining == TIME_W'(1)) begin
                            st       <= ST_DONE;
                            done     <= 1'b1;
                            beep     <= 1'b1;
                            beep_cnt <= '0;
                        end
                    end
                end
                ST_PAUSED: begin
                    if (clear_edge) begin
                        st        <= ST_IDLE;
                        remaining <= '0;
                    end else if (!door_closed) begin
                        st <= ST_PAUSED;
                    end else if (stop_edge) begin
                        st        <= ST_IDLE;
                        remaining <= '0;
                    end else if (start_edge) begin
                        st <= ST_COOKING;
                    end
                end
                ST_DONE: begin
                    if (clear_edge || !door_closed || stop_edge || start_edge) begin
                        st   <= ST_IDLE;
                        beep <= 1'b0;
                    end else if (tick) begin
                        if (beep_cnt == BEEP_LAST) begin
                            st   <= ST_IDLE;
                            beep <= 1'b0;
                        end else begin
                            beep_cnt <= beep_cnt + BEEP_W'(1);
                        end
                    end
                end
                default: st <= ST_IDLE;
            endcase
        end
    end

    assign state        = st;
    assign magnetron_on = (st == ST_COOKING) && door_closed;
    assign lamp_on      = (st == ST_COOKING) || !door_closed;

endmodule
